sram_async_ctrl: RTL and testbench

- Timing controller between the 6502 core's simple memory bus and the external 8-bit asynchronous SRAM (A0..A18, D0..D7, CEn, WEn, OEn).
- Turns single-cycle requests into properly sequenced SRAM read and write cycles: address setup, strobe pulse width, and data hold.
- Guarantees no bus contention on the shared data pins.
- Sits directly downstream of the CPU/test unit and directly upstream of the top-level pin drivers and bidirectional IO buffers.

---
 rtl/sram_async_ctrl.sv | 150 +++++++++++++++
 tb/tb_sram_async_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_async_ctrl.sv
// sram_async_ctrl: sequences single-cycle CPU bus requests into timed
// asynchronous SRAM read/write cycles (address setup, strobe width, hold).
// Every SRAM-side output comes straight from a flop, so nothing on the pins
// depends combinationally on req.
// Optional macro SRAM_BANK_EN adds a 3-bit bank register that drives
// sram_addr[18:16]. Without it, those address bits are tied to 0.
module sram_async_ctrl #(
   parameter int WR_CYCLES = 2,
   parameter int RD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        ack,
   output logic        busy,
   output logic [18:0] sram_addr,
   output logic        sram_ce_n,
   output logic        sram_we_n,
   output logic        sram_oe_n,
   output logic        sram_dq_oe,
   output logic [7:0]  sram_dq_out,
   input  logic [7:0]  sram_dq_in
`ifdef SRAM_BANK_EN
   ,
   input  logic        bank_we,
   input  logic [2:0]  bank_wdata
`endif
);

   // Out-of-range cycle counts are clamped to what the 4-bit counter can sequence.
   localparam int WR_C = (WR_CYCLES < 1) ? 1 : (WR_CYCLES > 15) ? 15 : WR_CYCLES;
   localparam int RD_C = (RD_CYCLES < 1) ? 1 : (RD_CYCLES > 15) ? 15 : RD_CYCLES;
   localparam logic [3:0] WR_LOAD = 4'(WR_C - 1);
   localparam logic [3:0] RD_LOAD = 4'(RD_C - 1);

   typedef enum logic [2:0] {IDLE, SETUP, WPULSE, WHOLD, RWAIT} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        wr_q;
   logic [18:0] addr_q;
   logic [7:0]  dout_q;
   logic [7:0]  rdata_q;
   logic        ack_q, busy_q;
   logic        ce_n_q, we_n_q, oe_n_q, dq_oe_q;
   logic [2:0]  bank_d;

`ifdef SRAM_BANK_EN
   logic [2:0] bank_q;

   // Bank register: writable in any state. A request accepted on the same edge
   // sees the old value, because it samples bank_q before this update lands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        bank_q <= 3'd0;
      else if (bank_we) bank_q <= bank_wdata;
   end

   assign bank_d = bank_q;
`else
   assign bank_d = 3'd0;
`endif

   // Transfer FSM. Strobes, address and data are registered here; the counter
   // times both WPULSE and RWAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= 19'd0;
         dout_q  <= 8'd0;
         rdata_q <= 8'd0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         ce_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            IDLE: if (req) begin
               state_q <= SETUP;
               wr_q    <= we;
               addr_q  <= {bank_d, addr};
               dout_q  <= wdata;
               busy_q  <= 1'b1;
               ce_n_q  <= 1'b0;
               // Reads enable the SRAM output; writes drive the bus. Never both.
               if (we) dq_oe_q <= 1'b1;
               else    oe_n_q  <= 1'b0;
            end
            SETUP: begin
               if (wr_q) begin
                  state_q <= WPULSE;
                  we_n_q  <= 1'b0;
                  cnt_q   <= WR_LOAD;
               end else begin
                  state_q <= RWAIT;
                  cnt_q   <= RD_LOAD;
               end
            end
            WPULSE: begin
               if (cnt_q == 4'd0) begin
                  state_q <= WHOLD;
                  we_n_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            WHOLD: begin
               // Data was held through the we_n rising edge. Release the bus now.
               state_q <= IDLE;
               ce_n_q  <= 1'b1;
               dq_oe_q <= 1'b0;
               ack_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
            RWAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= IDLE;
                  rdata_q <= sram_dq_in;
                  ce_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  ack_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rdata       = rdata_q;
   assign ack         = ack_q;
   assign busy        = busy_q;
   assign sram_addr   = addr_q;
   assign sram_ce_n   = ce_n_q;
   assign sram_we_n   = we_n_q;
   assign sram_oe_n   = oe_n_q;
   assign sram_dq_oe  = dq_oe_q;
   assign sram_dq_out = dout_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Directed bench for sram_async_ctrl. It includes a behavioural async SRAM
// and a per-cycle bus invariant checker.
module tb_sram_async_ctrl;

   logic        clk = 1'b0;
   logic        reset, req, we;
   logic [15:0] addr;
   logic [7:0]  wdata, rdata;
   logic        ack, busy;
   logic [18:0] sram_addr;
   logic        sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe;
   logic [7:0]  sram_dq_out, sram_dq_in;
`ifdef SRAM_BANK_EN
   logic        bank_we;
   logic [2:0]  bank_wdata;
`endif

   int ncmp = 0;
   int nfail = 0;

   logic [7:0]  mem [0:65535];
   logic [18:0] prev_addr;
   logic        prev_ce_n;

   sram_async_ctrl dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .busy(busy), .sram_addr(sram_addr),
      .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
      .sram_dq_oe(sram_dq_oe), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in)
`ifdef SRAM_BANK_EN
      , .bank_we(bank_we), .bank_wdata(bank_wdata)
`endif
   );

   always #5 clk = ~clk;

   // Async SRAM model: it writes on the rising edge of we_n and drives data when enabled.
   always @(posedge sram_we_n)
      if (sram_ce_n === 1'b0) mem[sram_addr[15:0]] = sram_dq_out;
   assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[15:0]] : 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Strobe bundle: {ce_n, we_n, oe_n, dq_oe}.
   function automatic logic [3:0] strb();
      return {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe};
   endfunction

   // Bus invariants, checked on every falling edge.
   always @(negedge clk) begin
      chk("inv_oe_vs_drive", {31'd0, (!sram_oe_n && sram_dq_oe)}, 32'd0);
      chk("inv_we_vs_drive", {31'd0, (!sram_we_n && !sram_dq_oe)}, 32'd0);
      if (prev_ce_n === 1'b0 && sram_ce_n === 1'b0)
         chk("inv_addr_stable", {13'd0, sram_addr}, {13'd0, prev_addr});
      prev_addr = sram_addr;
      prev_ce_n = sram_ce_n;
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      prev_addr = '0; prev_ce_n = 1'b1;
      reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef SRAM_BANK_EN
      bank_we = 1'b0; bank_wdata = 3'd0;
`endif
      #2;
      chk("rst_strb", strb(), 4'b1110);
      chk("rst_addr", sram_addr, 0);
      chk("rst_dqout", sram_dq_out, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_ackbusy", {ack, busy}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Idle with no requests.
      for (int i = 0; i < 20; i++) begin
         tick;
         chk("idle", {strb(), ack, busy, rdata}, {4'b1110, 2'b00, 8'h00});
      end

      // Write A5 to 1234.
      req = 1; we = 1; addr = 16'h1234; wdata = 8'hA5;
      tick;  // E0
      req = 0; we = 0; addr = 0; wdata = 0;
      chk("wr_setup_strb", strb(), 4'b0111);
      chk("wr_setup_addr", sram_addr, 19'h01234);
      chk("wr_setup_dq", sram_dq_out, 8'hA5);
      chk("wr_setup_ab", {ack, busy}, 2'b01);
      tick;  // E1
      chk("wr_pulse1", strb(), 4'b0011);
      tick;  // E2
      chk("wr_pulse2", strb(), 4'b0011);
      chk("wr_pulse2_dq", sram_dq_out, 8'hA5);
      tick;  // E3
      chk("wr_hold", strb(), 4'b0111);
      chk("wr_hold_dq", {sram_addr, sram_dq_out}, {19'h01234, 8'hA5});
      chk("wr_hold_ack", ack, 0);
      tick;  // E4
      chk("wr_ack", {ack, busy, strb()}, {2'b10, 4'b1110});
      chk("wr_idle_addr", sram_addr, 19'h01234);
      tick;
      chk("wr_ack_drop", ack, 0);
      chk("wr_mem", mem[16'h1234], 8'hA5);

      // Read from 1234.
      req = 1; we = 0; addr = 16'h1234;
      tick;  // E0
      req = 0; addr = 0;
      chk("rd_setup", {strb(), ack, busy}, {4'b0100, 2'b01});
      tick;  // E1
      chk("rd_wait1", {strb(), ack, rdata}, {4'b0100, 1'b0, 8'h00});
      tick;  // E2
      chk("rd_wait2", {strb(), ack}, {4'b0100, 1'b0});
      tick;  // E3
      chk("rd_ack", {ack, busy, strb()}, {2'b10, 4'b1110});
      chk("rd_data", rdata, 8'hA5);
      tick;
      chk("rd_hold", {ack, rdata}, {1'b0, 8'hA5});

      // Back-to-back write then read, with req held high across ack.
      req = 1; we = 1; addr = 16'h0055; wdata = 8'h3C;
      tick;  // E0
      we = 0; wdata = 8'h00;
      chk("b2b_wr_setup", {strb(), sram_dq_out}, {4'b0111, 8'h3C});
      tick;
      chk("b2b_ignored1", {strb(), sram_dq_out}, {4'b0011, 8'h3C});
      tick;
      chk("b2b_ignored2", strb(), 4'b0011);
      tick;
      chk("b2b_hold", {strb(), sram_dq_out}, {4'b0111, 8'h3C});
      tick;  // ack cycle: ce_n high for this one idle cycle
      chk("b2b_wr_ack", {ack, busy, strb()}, {2'b10, 4'b1110});
      tick;  // second transaction accepted at the ack edge
      req = 0;
      chk("b2b_rd_setup", {strb(), ack, busy}, {4'b0100, 2'b01});
      chk("b2b_rd_addr", sram_addr, 19'h00055);
      tick;
      tick;
      chk("b2b_rd_noack", ack, 0);
      tick;
      chk("b2b_rd_ack", {ack, rdata}, {1'b1, 8'h3C});

      // Reset asserted during WPULSE.
      req = 1; we = 1; addr = 16'h0777; wdata = 8'h11;
      tick;  // E0
      req = 0;
      tick;  // E1
      chk("mid_pulse", strb(), 4'b0011);
      #2 reset = 1;
      #1;
      chk("mid_rst_strb", strb(), 4'b1110);
      chk("mid_rst_ab", {ack, busy}, 2'b00);
      chk("mid_rst_addr", sram_addr, 0);
      @(posedge clk);
      #1 reset = 0;
      tick;
      chk("post_rst_idle", {strb(), busy}, {4'b1110, 1'b0});
      req = 1; we = 0; addr = 16'h1234;
      tick;
      req = 0;
      chk("post_rst_accept", {strb(), busy}, {4'b0100, 1'b1});
      tick;
      tick;
      tick;
      chk("post_rst_rd", {ack, rdata}, {1'b1, 8'hA5});

`ifdef SRAM_BANK_EN
      bank_we = 1; bank_wdata = 3'h5;
      tick;
      bank_we = 0;
      req = 1; we = 0; addr = 16'hFFFF;
      tick;  // E0
      req = 0;
      chk("bank_addr", sram_addr, 19'h5FFFF);
      bank_we = 1; bank_wdata = 3'h2;
      tick;
      bank_we = 0;
      chk("bank_mid1", sram_addr, 19'h5FFFF);
      tick;
      tick;
      chk("bank_ack", {ack, sram_addr}, {1'b1, 19'h5FFFF});
      tick;
      chk("bank_idle", sram_addr, 19'h5FFFF);
      req = 1; addr = 16'h0001; bank_we = 1; bank_wdata = 3'h7;
      tick;  // the request uses the old bank
      req = 0; bank_we = 0;
      chk("bank_same_cycle", sram_addr, 19'h20001);
      tick;
      tick;
      tick;
      chk("bank_rd2_ack", ack, 1);
      req = 1; addr = 16'h0002;
      tick;
      req = 0;
      chk("bank_new", sram_addr, 19'h70002);
      repeat (4) tick;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
